// File: rtl/cla_bist_driver.sv
`default_nettype none
// ============================================================================
//  Module      : cla_bist_driver
//  Description : Exhaustive self-test driver/checker for a carry-lookahead
//                adder; sweeps every {cin,y,x} and compares {cout,z}.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_bist_driver #(
    parameter int WIDTH        = 4,
    parameter int LATENCY      = 1,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    output logic [WIDTH-1:0]     x,
    output logic [WIDTH-1:0]     y,
    output logic                 cin,
    input  logic [WIDTH-1:0]     z,
    input  logic                 cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [2*WIDTH:0]     fail_vec,
    output logic [WIDTH:0]       fail_rsp
);

    localparam int c_VW = 2*WIDTH + 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RUN   = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_FAIL  = 3'd4;

    logic [2:0]      r_state;
    logic [3:0]      r_drain;
    logic [LATENCY-1:0] r_dl_valid;
    logic [c_VW-1:0] r_dl_vec [LATENCY];
    logic [WIDTH:0]  r_dl_exp [LATENCY];

    logic [c_VW-1:0] w_vec;
    logic [WIDTH:0]  w_exp;
    logic [WIDTH:0]  w_rsp;
    logic            w_active;
    logic            w_idle_like;
    logic            w_mis;
    logic            w_stop;

    assign w_vec       = {cin, y, x};
    assign w_exp       = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign w_rsp       = {cout, z};
    assign w_active    = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign w_idle_like = (r_state == c_IDLE) || (r_state == c_DONE) || (r_state == c_FAIL);
    // Case inequality so that unknown adder outputs are flagged as mismatches.
    assign w_mis       = w_active && r_dl_valid[LATENCY-1] && (w_rsp !== r_dl_exp[LATENCY-1]);
    assign w_stop      = w_mis && (STOP_ON_FAIL != 0);

    // Expected-result delay line, aligned with the adder pipeline.
    always_ff @(posedge clk) begin
        if (!res || (w_idle_like && start)) begin
            r_dl_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dl_vec[i] <= '0;
                r_dl_exp[i] <= '0;
            end
        end else begin
            r_dl_valid[0] <= (r_state == c_RUN);
            r_dl_vec[0]   <= w_vec;
            r_dl_exp[0]   <= w_exp;
            for (int i = 1; i < LATENCY; i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_vec[i]   <= r_dl_vec[i-1];
                r_dl_exp[i]   <= r_dl_exp[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state   <= c_IDLE;
            r_drain   <= '0;
            x         <= '0;
            y         <= '0;
            cin       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            fail_rsp  <= '0;
        end else begin
            if (w_mis) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'd0) begin
                    fail_vec <= r_dl_vec[LATENCY-1];
                    fail_rsp <= w_rsp;
                end
            end
            case (r_state)
                c_IDLE, c_DONE, c_FAIL: begin
                    if (start) begin
                        r_state     <= c_RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        err_count   <= '0;
                        fail_vec    <= '0;
                        fail_rsp    <= '0;
                        {cin, y, x} <= '0;
                    end
                end
                c_RUN: begin
                    if (w_stop) begin
                        r_state     <= c_FAIL;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pass        <= 1'b0;
                        {cin, y, x} <= '0;
                    end else if (&w_vec) begin
                        r_state     <= c_DRAIN;
                        r_drain     <= '0;
                        {cin, y, x} <= '0;
                    end else begin
                        {cin, y, x} <= w_vec + c_VW'(1);
                    end
                end
                c_DRAIN: begin
                    if (w_stop) begin
                        r_state <= c_FAIL;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                    end else if (r_drain == 4'(LATENCY-1)) begin
                        r_state <= c_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == 16'd0) && !w_mis;
                    end else begin
                        r_drain <= r_drain + 4'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_bist_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_bist_driver
//  Description : Self-checking bench; two driver instances facing adder
//                models with selectable faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_bist_driver;

    localparam int LA = 1;
    localparam int LB = 3;

    logic clk = 1'b0;
    logic res;
    logic start;
    always #5 clk = ~clk;

    logic [3:0]  xa, ya, za, xb, yb, zb;
    logic        cina, couta, cinb, coutb;
    logic        busya, donea, passa, busyb, doneb, passb;
    logic [15:0] erra, errb;
    logic [8:0]  fva, fvb;
    logic [4:0]  fra, frb;

    cla_bist_driver #(.WIDTH(4), .LATENCY(LA), .STOP_ON_FAIL(0)) u_dut_a (
        .clk(clk), .res(res), .start(start), .x(xa), .y(ya), .cin(cina),
        .z(za), .cout(couta), .busy(busya), .done(donea), .pass(passa),
        .err_count(erra), .fail_vec(fva), .fail_rsp(fra)
    );

    cla_bist_driver #(.WIDTH(4), .LATENCY(LB), .STOP_ON_FAIL(1)) u_dut_b (
        .clk(clk), .res(res), .start(start), .x(xb), .y(yb), .cin(cinb),
        .z(zb), .cout(coutb), .busy(busyb), .done(doneb), .pass(passb),
        .err_count(errb), .fail_vec(fvb), .fail_rsp(frb)
    );

    // Fault selection per adder model: 0 none, 1 z[0] stuck-0, 2 cout stuck-0,
    // 3 xor-corrupt the vectors matching a random key.
    int          mode [2];
    logic [8:0]  key  [2];
    logic [8:0]  kmask[2];
    logic [4:0]  xmask[2];

    int checks = 0;
    int errors = 0;

    function automatic logic [4:0] adder_out(int d, logic [8:0] v);
        int s;
        logic [4:0] r;
        s = int'(v) % 16 + (int'(v) / 16) % 16 + int'(v) / 256;
        r = 5'(s);
        case (mode[d])
            1: r[0] = 1'b0;
            2: r[4] = 1'b0;
            3: if (((v ^ key[d]) & kmask[d]) == 9'd0) r = r ^ xmask[d];
            default: ;
        endcase
        return r;
    endfunction

    logic [4:0] pa;
    logic [4:0] pb [3];
    always @(posedge clk) begin
        pa    <= adder_out(0, {cina, ya, xa});
        pb[0] <= adder_out(1, {cinb, yb, xb});
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign {couta, za} = pa;
    assign {coutb, zb} = pb[2];

    typedef struct {
        int done_r;
        int busy_last;
        int err;
        int fvec;
        int frsp;
        int pass;
    } exp_t;

    // Whole-run expectation, relative cycle 1 = the cycle after the start edge.
    function automatic exp_t model(int d, int lat, bit stop);
        exp_t e;
        int cnt, first, sum;
        logic [4:0] r;
        cnt = 0; first = -1; e.frsp = 0;
        for (int i = 0; i < 512; i++) begin
            sum = i % 16 + (i / 16) % 16 + i / 256;
            r = adder_out(d, 9'(i));
            if (int'(r) != sum) begin
                cnt++;
                if (first < 0) begin
                    first  = i;
                    e.frsp = int'(r);
                end
            end
        end
        if (stop && first >= 0) begin
            e.done_r = first + lat + 2;
            e.err    = 1;
            e.pass   = 0;
        end else begin
            e.done_r = 513 + lat;
            e.err    = (cnt > 65535) ? 65535 : cnt;
            e.pass   = (cnt == 0) ? 1 : 0;
        end
        e.fvec      = (first < 0) ? 0 : first;
        e.busy_last = e.done_r - 1;
        return e;
    endfunction

    function automatic logic [8:0] exp_drive(exp_t e, int r);
        return (r <= e.busy_last && r <= 512) ? 9'(r - 1) : 9'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string name);
        exp_t ea, eb;
        int bb_a, bd_a, bx_a, bb_b, bd_b, bx_b;
        ea = model(0, LA, 1'b0);
        eb = model(1, LB, 1'b1);
        bb_a = 0; bd_a = 0; bx_a = 0; bb_b = 0; bd_b = 0; bx_b = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int r = 1; r <= 560; r++) begin
            if (busya !== 1'(r <= ea.busy_last)) bb_a++;
            if (donea !== 1'(r >= ea.done_r))    bd_a++;
            if ({cina, ya, xa} !== exp_drive(ea, r)) bx_a++;
            if (busyb !== 1'(r <= eb.busy_last)) bb_b++;
            if (doneb !== 1'(r >= eb.done_r))    bd_b++;
            if ({cinb, yb, xb} !== exp_drive(eb, r)) bx_b++;
            @(negedge clk);
        end
        check({name, " A busy-cycles"}, 64'(bb_a), 64'd0);
        check({name, " A done-cycles"}, 64'(bd_a), 64'd0);
        check({name, " A drive-seq"},   64'(bx_a), 64'd0);
        check({name, " A err_count"},   64'(erra), 64'(ea.err));
        check({name, " A pass"},        64'(passa), 64'(ea.pass));
        check({name, " A fail_vec"},    64'(fva),  64'(ea.fvec));
        check({name, " A fail_rsp"},    64'(fra),  64'(ea.frsp));
        check({name, " B busy-cycles"}, 64'(bb_b), 64'd0);
        check({name, " B done-cycles"}, 64'(bd_b), 64'd0);
        check({name, " B drive-seq"},   64'(bx_b), 64'd0);
        check({name, " B err_count"},   64'(errb), 64'(eb.err));
        check({name, " B pass"},        64'(passb), 64'(eb.pass));
        check({name, " B fail_vec"},    64'(fvb),  64'(eb.fvec));
        check({name, " B fail_rsp"},    64'(frb),  64'(eb.frsp));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " A outputs"}, 64'({xa, ya, cina, busya, donea, passa, erra, fva, fra}), 64'd0);
        check({tag, " B outputs"}, 64'({xb, yb, cinb, busyb, doneb, passb, errb, fvb, frb}), 64'd0);
    endtask

    initial begin
        exp_t eh;
        int bad;
        res = 1'b0; start = 1'b0;
        mode = '{0, 0}; key = '{9'd0, 9'd0}; kmask = '{9'd0, 9'd0}; xmask = '{5'd0, 5'd0};
        repeat (2) @(negedge clk);
        res = 1'b1;
        repeat (3) @(negedge clk);
        res = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle reset");
        res = 1'b1;

        run("clean");
        mode = '{1, 1};
        run("z0_stuck");
        mode = '{2, 2};
        run("cout_stuck");
        for (int t = 0; t < 2; t++) begin
            mode = '{3, 3};
            for (int d = 0; d < 2; d++) begin
                key[d]   = 9'($urandom);
                kmask[d] = 9'($urandom_range(1, 511));
                xmask[d] = 5'($urandom_range(1, 31));
            end
            run("random");
        end

        // Reset in the middle of a failing run must abandon it completely.
        mode = '{1, 0};
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        check("midrun A vec", 64'({cina, ya, xa}), 64'd100);
        check("midrun A errs-before-reset", 64'(erra != 16'd0), 64'd1);
        res = 1'b0;
        @(negedge clk);
        check_all_zero("midrun reset");
        res = 1'b1;
        mode = '{0, 0};
        run("after_reset");

        // start held high: restart on the first DONE cycle.
        eh  = model(0, LA, 1'b0);
        bad = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        for (int r = 1; r <= eh.done_r; r++) begin
            if (busya !== 1'(r <= eh.busy_last)) bad++;
            if (donea !== 1'(r >= eh.done_r))    bad++;
            if ({cina, ya, xa} !== exp_drive(eh, r)) bad++;
            @(negedge clk);
        end
        check("hold run-trace", 64'(bad), 64'd0);
        check("hold restart busy/done/vec", 64'({busya, donea, cina, ya, xa}), {53'd0, 2'b10, 9'd0});
        @(negedge clk);
        check("hold restart next vec", 64'({cina, ya, xa}), 64'd1);
        start = 1'b0;
        res   = 1'b0;
        @(negedge clk);
        res   = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
